// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code decoder (E0/F0 prefix FSM) feeding an in-order key-event queue.
// Optional typematic repeat suppression is built when PS2_REPEAT_FILTER_EN is defined.
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       inclock,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic [7:0] evt_ascii,
    output logic       evt_release,
    output logic       evt_ext,
    output logic [3:0] fifo_count,
    output logic       overflow
);

    localparam int                DATA_W   = 8;
    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [3:0]        FULL_CNT = 4'(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] PFX_EXT  = 8'hE0;
    localparam logic [DATA_W-1:0] PFX_BRK  = 8'hF0;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t            state;
    state_t            state_nxt;

    logic              dec_emit_p0;
    logic              dec_release_p0;
    logic              dec_ext_p0;
    logic [DATA_W-1:0] dec_ascii_p0;
    logic              repeat_hit_p0;

    logic [DATA_W-1:0] code_mem_p1  [FIFO_DEPTH];
    logic [DATA_W-1:0] ascii_mem_p1 [FIFO_DEPTH];
    logic              rel_mem_p1   [FIFO_DEPTH];
    logic              ext_mem_p1   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              full;
    logic              pop;
    logic              push_req;
    logic              push;

    // Controller status/ack bytes that never belong to a key sequence.
    function automatic logic is_noise(input logic [DATA_W-1:0] b);
        logic r;
        r = (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
            (b == 8'hFE) || (b == 8'hFF);
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] ascii_of(input logic [DATA_W-1:0] code,
                                                   input logic              ext);
        logic [DATA_W-1:0] r;
        if (ext) begin
            r = 8'h00;
        end else begin
            case (code)
                8'h15:   r = 8'd81;
                8'h1C:   r = 8'd65;
                8'h32:   r = 8'd66;
                8'h21:   r = 8'd67;
                default: r = 8'd32;
            endcase
        end
        return r;
    endfunction

    // Stage p0: prefix decode of the incoming byte
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (rx_valid) begin
            if (is_noise(rx_data)) begin
                state_nxt = IDLE;
            end else if (rx_data == PFX_EXT) begin
                state_nxt = (state == BRK || state == EXT_BRK) ? EXT_BRK : EXT;
            end else if (rx_data == PFX_BRK) begin
                state_nxt = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_comb begin
        dec_emit_p0    = rx_valid && !is_noise(rx_data) &&
                         (rx_data != PFX_EXT) && (rx_data != PFX_BRK);
        dec_release_p0 = (state == BRK) || (state == EXT_BRK);
        dec_ext_p0     = (state == EXT) || (state == EXT_BRK);
        dec_ascii_p0   = ascii_of(rx_data, dec_ext_p0);
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic [DATA_W:0] last_make;
    logic            last_make_vld;
    logic            key_match;

    assign key_match     = last_make_vld && (last_make == {rx_data, dec_ext_p0});
    assign repeat_hit_p0 = !dec_release_p0 && key_match;

    // Remembers the last make that got through; its own break re-arms the key.
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            last_make     <= '0;
            last_make_vld <= 1'b0;
        end else if (dec_emit_p0) begin
            if (!dec_release_p0 && !key_match) begin
                last_make     <= {rx_data, dec_ext_p0};
                last_make_vld <= 1'b1;
            end else if (dec_release_p0 && key_match) begin
                last_make_vld <= 1'b0;
            end
        end
    end
`else
    assign repeat_hit_p0 = 1'b0;
`endif

    // Stage p1: event queue
    assign full     = (fifo_count == FULL_CNT);
    assign pop      = evt_valid && evt_ready;
    assign push_req = dec_emit_p0 && !repeat_hit_p0;
    assign push     = push_req && (!full || pop);

    always_ff @(posedge inclock) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                code_mem_p1[i]  <= '0;
                ascii_mem_p1[i] <= '0;
                rel_mem_p1[i]   <= 1'b0;
                ext_mem_p1[i]   <= 1'b0;
            end
        end else begin
            // When full with a pop, wr_ptr == rd_ptr: the head slot is refilled as it leaves.
            if (push) begin
                code_mem_p1[wr_ptr]  <= rx_data;
                ascii_mem_p1[wr_ptr] <= dec_ascii_p0;
                rel_mem_p1[wr_ptr]   <= dec_release_p0;
                ext_mem_p1[wr_ptr]   <= dec_ext_p0;
                wr_ptr               <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 4'd1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 4'd1;
            end
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign evt_valid   = (fifo_count != 4'd0);
    assign evt_code    = code_mem_p1[rd_ptr];
    assign evt_ascii   = ascii_mem_p1[rd_ptr];
    assign evt_release = rel_mem_p1[rd_ptr];
    assign evt_ext     = ext_mem_p1[rd_ptr];

endmodule

// File: doc/ps2_key_event_ctrl.md
PS2_KEY_EVENT_CTRL -- requirements
Module: ps2_key_event_ctrl

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, default 8, event-queue depth; legal values 2, 4, 8.
REQ-002 SHALL have port: inclock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: rx_data  input  8  received PS/2 byte from the PS/2 controller.
REQ-005 SHALL have port: rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-006 SHALL have port: evt_ready  input  1  consumer accepts the head event.
REQ-007 SHALL have port: evt_valid  output  1  head event available.
REQ-008 SHALL have port: evt_code  output  8  raw scan code of the head event.
REQ-009 SHALL have port: evt_ascii  output  8  ASCII of the head event.
REQ-010 SHALL have port: evt_release  output  1  head event is a key release (break).
REQ-011 SHALL have port: evt_ext  output  1  head event is an extended (E0-prefixed) key.
REQ-012 SHALL have port: fifo_count  output  4  queued events, 0..FIFO_DEPTH.
REQ-013 SHALL have port: overflow  output  1  sticky flag, event dropped on full queue.

Function
REQ-014 SHALL decode with FSM states IDLE, EXT, BRK and EXT_BRK, advancing only on cycles where rx_valid=1.
REQ-015 SHALL transition: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; BRK+E0->EXT_BRK.
REQ-016 SHALL hold state when a prefix byte repeats (EXT+E0, BRK+F0, EXT_BRK+E0/F0).
REQ-017 SHALL, on any other byte, emit one event and return to IDLE; the event carries: code=byte, release=1 iff state is BRK/EXT_BRK, ext=1 iff state is EXT/EXT_BRK.
REQ-018 SHALL discard the bytes 00, AA, FA, FE and FF in every state, return to IDLE and emit no event.
REQ-019 SHALL map ascii for non-extended events: 15->81 'Q', 1C->65 'A', 32->66 'B', 21->67 'C', all other codes->32; extended events use ascii 00.
REQ-020 SHALL write an emitted event into the FIFO on the same edge that samples the final byte; evt_valid is visible the next cycle (latency 1 clock).
REQ-021 SHALL drive evt_valid=(fifo_count!=0); evt_code/ascii/release/ext SHALL present the head entry; they are don't-care while evt_valid=0.
REQ-022 SHALL pop the head entry on an edge where evt_valid=1 and evt_ready=1; evt_ready while empty SHALL have no effect.
REQ-023 SHALL, when a push and a pop occur on the same edge, do both and leave fifo_count unchanged, including when the queue is full.
REQ-024 SHALL, when a push occurs while full without a pop, drop the new event, leave the queue intact and set overflow=1 until reset.
REQ-025 SHALL wrap read and write pointers modulo FIFO_DEPTH and preserve FIFO order.

Reset
REQ-026 SHALL, with resetn=0 at an edge, set FSM=IDLE, fifo_count=0, evt_valid=0, overflow=0 and pointers=0, and clear the repeat-filter register.
REQ-027 SHALL ignore rx_valid and evt_ready while resetn=0; a partially decoded prefix sequence is abandoned.
REQ-028 SHALL drive evt_code, evt_ascii, evt_release and evt_ext to 0 out of reset until the first push.

Configuration
REQ-029 SHALL honour macro PS2_REPEAT_FILTER_EN; when defined, a non-release event whose {code,ext} equals the last accepted make, with no intervening release of that key, SHALL NOT be pushed (typematic suppression); a matching release clears the filter.
REQ-030 SHALL, when PS2_REPEAT_FILTER_EN is undefined, push every make event, including typematic repeats; the filter register SHALL not be built.

Verification
REQ-031 SHALL verify: bytes 1C, F0, 1C with evt_ready=1 -> two events: {1C,65,rel0,ext0} then {1C,65,rel1,ext0}; each appears 1 cycle after its final byte.
REQ-032 SHALL verify: bytes E0, F0, 75 -> one event {75,00,rel1,ext1}; FSM returns to IDLE.
REQ-033 SHALL verify: evt_ready=0, ten make codes (15 then 9 others) -> fifo_count=8, overflow=1; pops return the first eight in order, with head ascii 81.
REQ-034 SHALL verify: queue full, and push and pop on the same edge -> fifo_count stays 8, overflow stays 0.
REQ-035 SHALL verify: bytes 15, 15, 15, F0, 15, 15 -> with PS2_REPEAT_FILTER_EN: 3 events (make, break, make); without it: 5 events.
REQ-036 SHALL verify: byte E0, then resetn=0 for one cycle, then byte 1C -> event {1C,65,rel0,ext0}; fifo_count=0 and overflow=0 immediately after reset; byte AA -> no event.
